// File: rtl/clk_div_prog.sv
// Programmable clock divider: two-state HIGH/LOW FSM with a down-counter; new divisors apply at LOW->HIGH.
// Optional registered tick output enabled by defining CLK_DIV_PROG_TICK_EN.
module clk_div_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 6
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             div_wr,
    input  logic [WIDTH-1:0] div_val,
    output logic             div_busy,
    output logic [WIDTH-1:0] div_cur,
`ifdef CLK_DIV_PROG_TICK_EN
    output logic             tick,
`endif
    output logic             clk_out
);

    localparam logic [WIDTH-1:0] DEF_DIV = (DEFAULT_DIV < 2) ? WIDTH'(2) : WIDTH'(DEFAULT_DIV);

    typedef enum logic {LOW = 1'b0, HIGH = 1'b1} state_t;

    function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] d);
        return (d < WIDTH'(2)) ? WIDTH'(2) : d;
    endfunction

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] cur_reg, cur_next;
    logic [WIDTH-1:0] pend_reg, pend_next;
    logic             busy_reg, busy_next;
    logic [WIDTH-1:0] apply_div;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cur_next   = cur_reg;
        pend_next  = pend_reg;
        busy_next  = busy_reg;
        // The divisor that takes effect if this edge starts a new period
        apply_div  = busy_reg ? pend_reg : cur_reg;
        if (en) begin
            if (cnt_reg != '0) begin
                cnt_next = cnt_reg - WIDTH'(1);
            end else if (state_reg == LOW) begin
                state_next = HIGH;
                cur_next   = apply_div;
                cnt_next   = apply_div - (apply_div >> 1) - WIDTH'(1);
                busy_next  = 1'b0;
            end else begin
                state_next = LOW;
                cnt_next   = (cur_reg >> 1) - WIDTH'(1);
            end
        end
        // A write on the applying edge wins over the clear, so it stays pending for the next period
        if (div_wr) begin
            pend_next = clamp_div(div_val);
            busy_next = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_reg <= LOW;
            cnt_reg   <= '0;
            cur_reg   <= DEF_DIV;
            pend_reg  <= DEF_DIV;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            cur_reg   <= cur_next;
            pend_reg  <= pend_next;
            busy_reg  <= busy_next;
        end
    end

`ifdef CLK_DIV_PROG_TICK_EN
    logic tick_reg;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            tick_reg <= 1'b0;
        end else begin
            tick_reg <= en && (state_reg == LOW) && (cnt_reg == '0);
        end
    end

    assign tick = tick_reg;
`endif

    assign clk_out  = state_reg;
    assign div_busy = busy_reg;
    assign div_cur  = cur_reg;

endmodule

// File: tb/tb_clk_div_prog.sv
// Randomized self-checking bench for clk_div_prog against a period-position reference model.
module tb_clk_div_prog;

    localparam int WIDTH = 8;
    localparam int DEF   = 6;

    logic             clk_in = 1'b0;
    logic             rst    = 1'b1;
    logic             en     = 1'b0;
    logic             div_wr = 1'b0;
    logic [WIDTH-1:0] div_val = '0;
    logic             div_busy;
    logic [WIDTH-1:0] div_cur;
    logic             clk_out;
`ifdef CLK_DIV_PROG_TICK_EN
    logic             tick;
`endif

    clk_div_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .en       (en),
        .div_wr   (div_wr),
        .div_val  (div_val),
        .div_busy (div_busy),
        .div_cur  (div_cur),
`ifdef CLK_DIV_PROG_TICK_EN
        .tick     (tick),
`endif
        .clk_out  (clk_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: position within the current output period
    int m_div  = DEF;
    int m_pend = 0;
    int m_busy = 0;
    int m_pos  = DEF - 1;
    int m_tick = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic int clampv(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    task automatic model_edge(input logic r, input logic e, input logic w, input int v);
        if (r) begin
            m_div  = DEF;
            m_busy = 0;
            m_pend = 0;
            m_pos  = m_div - 1;
            m_tick = 0;
        end else begin
            m_tick = 0;
            if (e) begin
                if (m_pos == m_div - 1) begin
                    if (m_busy != 0) m_div = m_pend;
                    m_busy = 0;
                    m_pos  = 0;
                    m_tick = 1;
                end else begin
                    m_pos++;
                end
            end
            if (w) begin
                m_pend = clampv(v);
                m_busy = 1;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic w, input int v);
        rst = r; en = e; div_wr = w; div_val = v[WIDTH-1:0];
        @(posedge clk_in);
        model_edge(r, e, w, v);
        @(negedge clk_in);
        check("clk_out", clk_out, (m_pos < m_div - m_div / 2) ? 1 : 0);
        check("div_cur", div_cur, m_div);
        check("div_busy", div_busy, m_busy);
`ifdef CLK_DIV_PROG_TICK_EN
        check("tick", tick, m_tick);
`endif
        if (w && !r) $display("WR  val=%0d -> pending=%0d cur=%0d busy=%0b", v, m_pend, div_cur, div_busy);
        if (r) $display("RST cur=%0d busy=%0b clk_out=%0b", div_cur, div_busy, clk_out);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 0);
    endtask

    task automatic run_until_pos(input int p);
        for (int k = 0; k < 300 && m_pos != p; k++) cycle(1'b0, 1'b1, 1'b0, 0);
    endtask

    initial begin
        // Reset state
        cycle(1'b1, 1'b1, 1'b1, 3);
        cycle(1'b1, 1'b0, 1'b0, 0);
        check("rst_clk_out", clk_out, 0);
        check("rst_div_cur", div_cur, 6);
        check("rst_busy", div_busy, 0);

        // First edge after reset raises clk_out; 3/3 pattern
        cycle(1'b0, 1'b1, 1'b0, 0);
        check("first_rise", clk_out, 1);
        run(13);

        // Write 5 in mid high phase
        run_until_pos(1);
        cycle(1'b0, 1'b1, 1'b1, 5);
        run(20);
        check("div5_cur", div_cur, 5);

        // Clamp low, then the widest divisor
        cycle(1'b0, 1'b1, 1'b1, 0);
        run(12);
        check("div0_cur", div_cur, 2);
        cycle(1'b0, 1'b1, 1'b1, 1);
        run(6);
        cycle(1'b0, 1'b1, 1'b1, 255);
        run(520);
        check("div255_cur", div_cur, 255);

        // Two writes in one period, last one wins
        cycle(1'b0, 1'b1, 1'b1, 7);
        run(3);
        cycle(1'b0, 1'b1, 1'b1, 9);
        run(300);
        check("div9_cur", div_cur, 9);

        // Write coinciding with the LOW->HIGH edge lands one period later
        run_until_pos(m_div - 1);
        cycle(1'b0, 1'b1, 1'b1, 4);
        check("coincide_cur", div_cur, 9);
        check("coincide_busy", div_busy, 1);
        run(20);
        check("coincide_applied", div_cur, 4);

        // Back to 6, then freeze during high phase and reset mid low phase
        cycle(1'b0, 1'b1, 1'b1, 6);
        run(20);
        run_until_pos(1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 0);
        check("frozen_high", clk_out, 1);
        run(6);
        run_until_pos(4);
        cycle(1'b0, 1'b1, 1'b1, 3);
        cycle(1'b1, 1'b1, 1'b0, 0);
        check("midrst_clk_out", clk_out, 0);
        check("midrst_cur", div_cur, 6);
        check("midrst_busy", div_busy, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic r, e, w;
            int   v;
            r = ($urandom_range(0, 499) == 0);
            e = ($urandom_range(0, 7) != 0);
            w = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 9))
                0:       v = 0;
                1:       v = 1;
                2:       v = $urandom_range(100, 255);
                default: v = $urandom_range(2, 12);
            endcase
            cycle(r, e, w, v);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the divisor, the counters and div_val/div_cur.
REQ-002 Parameter DEFAULT_DIV, default 6: active divisor after reset (50 MHz in -> 8.33 MHz out).
REQ-003 clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 en  input  1  count enable; 0 freezes all divider state.
REQ-006 div_wr  input  1  one-cycle write strobe for a new divisor.
REQ-007 div_val  input  WIDTH  new divisor, sampled when div_wr=1.
REQ-008 div_busy  output  1  1 while a written divisor is pending and not yet applied.
REQ-009 div_cur  output  WIDTH  divisor currently in effect.
REQ-010 clk_out  output  1  divided clock, driven directly from a register with no output decode.

Function
REQ-011 Output period SHALL be D clk_in cycles, where D is the active divisor: high phase H = D - floor(D/2) cycles, low phase L = floor(D/2) cycles.
REQ-012 Any divisor value below 2 (written or parameter) SHALL be clamped to 2.
REQ-013 The block SHALL be a two-state FSM, HIGH and LOW, with a down-counter cnt; clk_out SHALL be 1 exactly when the state is HIGH.
REQ-014 Transitions SHALL be as follows, with en=1 in every case:
- LOW with cnt==0 -> HIGH, cnt=H-1.
- HIGH with cnt==0 -> LOW, cnt=L-1.
- Otherwise cnt decrements and the state holds.
REQ-015 en=0 SHALL hold the state, cnt and clk_out unchanged; writes SHALL still be accepted while en=0.
REQ-016 div_wr=1 SHALL capture the clamped div_val into a pending register and set div_busy=1 on the next edge.
REQ-017 The pending divisor SHALL be applied only at the LOW->HIGH transition: div_cur updates and H is computed from the new divisor on that same edge; div_busy clears on that edge.
REQ-018 A write while div_busy=1 SHALL overwrite the pending value; only the last value written is applied.
REQ-019 If a write coincides with a LOW->HIGH edge, that edge SHALL apply the previously pending value (or keep div_cur if none is pending), and the new value SHALL become pending with div_busy remaining 1.
REQ-020 The output SHALL have no runt pulses: every high phase and every low phase SHALL be exactly H or L of a single divisor.

Reset
REQ-021 With rst=1 at a clock edge, the block SHALL enter: state LOW, cnt=0, clk_out=0, div_busy=0, div_cur=DEFAULT_DIV (clamped), with any pending divisor discarded.
REQ-022 rst SHALL take priority over en and div_wr.
REQ-023 With en=1, clk_out SHALL rise on the first edge after rst deasserts.
REQ-024 Reset asserted mid-period SHALL force clk_out=0 on that edge; no completion of the partial phase.

Configuration
REQ-025 Macro CLK_DIV_PROG_TICK_EN, when defined, SHALL add output port tick (output, 1 bit).
REQ-026 tick SHALL be registered and SHALL be 1 for exactly the one clk_in cycle in which clk_out first goes high after each LOW->HIGH edge; its reset value is 0.
REQ-027 Without CLK_DIV_PROG_TICK_EN, the tick port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-028 Reset, then en=1 held, DEFAULT_DIV=6 -> clk_out rises 1 cycle after reset, pattern 3 high / 3 low, period 6.
REQ-029 Write div_val=5 mid-high-phase -> div_busy=1 until the next rising edge of clk_out; the current period completes as 3/3; subsequent periods are 3 high / 2 low; div_cur=5.
REQ-030 Write div_val=0 -> clamped to 2, output toggles every cycle (1/1), div_cur=2; write div_val=255 -> 128 high / 127 low.
REQ-031 Two writes, 7 then 9, within one period -> only 9 is applied (5/4); a write coinciding with the LOW->HIGH edge is applied one period later.
REQ-032 en=0 for 4 cycles during high phase -> clk_out held at 1, and that phase stretches by exactly 4 cycles; then rst mid-low-phase -> clk_out=0, div_cur=6, div_busy=0.
REQ-033 With CLK_DIV_PROG_TICK_EN, D=4 -> tick=1 once every 4 cycles, aligned with the first high cycle of clk_out; tick=0 throughout reset.
